// File: rtl/distributore_sched.sv
// distributore_sched: shares one vending dispense mechanism among N_REQ
// distributore coin front-ends.
//
// Requests are latched into a pending vector and served round-robin. Each
// service is one fixed motor pulse, then a wait for the done sensor, then a
// one-cycle acknowledge back to the served front-end.
//
// Optional feature macro: DSCHED_TIMEOUT_EN
//   When defined, a WAIT_DONE cycle counter gives up after TIMEOUT cycles.
//   The unit is then dropped without an ack, and the sticky err_o is raised.
//   When undefined, WAIT_DONE waits indefinitely and err_o is tied to 0.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   req_i      per-front-end request, level-high
//   done_i     mechanism done sensor
//   motor_o    registered motor drive
//   sel_o      index of the granted front-end (held until next grant)
//   busy_o     high whenever the FSM is not in IDLE
//   pending_o  latched pending requests
//   ack_o      one-cycle one-hot served pulse
//   err_o      sticky timeout fault
module distributore_sched #(
    parameter int N_REQ     = 4,
    parameter int SEL_W     = 2,
    parameter int PULSE_LEN = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic             motor_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             busy_o,
    output logic [N_REQ-1:0] pending_o,
    output logic [N_REQ-1:0] ack_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT_DONE, ACK} state_t;

    state_t             state_q;
    logic [N_REQ-1:0]   pending_q;
    logic [N_REQ-1:0]   ack_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   last_q;
    logic [7:0]         cnt_q;
    logic               motor_q;

    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic [N_REQ-1:0]   clr;

`ifdef DSCHED_TIMEOUT_EN
    logic [7:0]         wcnt_q;
    logic               err_q;
    logic               timeout_hit;

    // Last permitted WAIT_DONE cycle passes without done_i.
    assign timeout_hit = (state_q == WAIT_DONE) && !done_i &&
                         (wcnt_q == 8'(TIMEOUT - 1));
`endif

    // Round-robin search: first pending unit starting just after last_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            logic [SEL_W-1:0] cand;
            cand = SEL_W'((int'(last_q) + k) % N_REQ);
            if (!grant_vld && pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Pending clear for the unit being retired (ack or timeout cleanup).
    always_comb begin
        clr = '0;
        if (state_q == ACK) clr[sel_q] = 1'b1;
`ifdef DSCHED_TIMEOUT_EN
        if (timeout_hit) clr[sel_q] = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ack_q     <= '0;
            sel_q     <= '0;
            last_q    <= SEL_W'(N_REQ - 1);
            cnt_q     <= '0;
            motor_q   <= 1'b0;
`ifdef DSCHED_TIMEOUT_EN
            wcnt_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            // Set wins over clear so a request arriving on the retire cycle survives.
            pending_q <= (pending_q & ~clr) | req_i;
            ack_q     <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        sel_q   <= grant_idx;
                        cnt_q   <= 8'(PULSE_LEN - 1);
                        motor_q <= 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == 8'd0) begin
                        motor_q <= 1'b0;
                        state_q <= WAIT_DONE;
`ifdef DSCHED_TIMEOUT_EN
                        wcnt_q  <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (done_i) begin
                        ack_q[sel_q] <= 1'b1;
                        state_q      <= ACK;
                    end
`ifdef DSCHED_TIMEOUT_EN
                    else if (timeout_hit) begin
                        last_q  <= sel_q;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
`endif
                end
                ACK: begin
                    last_q  <= sel_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign motor_o   = motor_q;
    assign sel_o     = sel_q;
    assign busy_o    = (state_q != IDLE);
    assign pending_o = pending_q;
    assign ack_o     = ack_q;
`ifdef DSCHED_TIMEOUT_EN
    assign err_o     = err_q;
`else
    assign err_o     = 1'b0;
`endif

endmodule
